// File: rtl/mic_capture_ctrl_pkg.sv
// mic_ctrl_pkg: shared definitions for the microphone capture controller.
//   - register word addresses of the Avalon-MM register file
//   - CTRL / STATUS bit positions
//   - ctrl_state_t session FSM encoding (also readable in STATUS[8:6])
//   - ARM / ABORT phase lengths in clock cycles
package mic_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL       = 3'd0;
    localparam logic [2:0] ADDR_STATUS     = 3'd1;
    localparam logic [2:0] ADDR_START_ADDR = 3'd2;
    localparam logic [2:0] ADDR_NUM_SAMPLES = 3'd3;
    localparam logic [2:0] ADDR_SAMPLE_DIV = 3'd4;
    localparam logic [2:0] ADDR_SAMPLE_CNT = 3'd5;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_HALF_IE = 2;
    localparam int CTRL_END_IE  = 3;
    localparam int CTRL_DONE_IE = 4;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_HALF_PEND = 1;
    localparam int STAT_END_PEND  = 2;
    localparam int STAT_DONE_PEND = 3;
    localparam int STAT_ABORTED   = 4;
    localparam int STAT_CFG_ERR   = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        RUN      = 3'd2,
        DONE     = 3'd3,
        ABORTING = 3'd4
    } ctrl_state_t;

    localparam int ARM_CYCLES   = 3;
    localparam int ABORT_CYCLES = 4;

endpackage

// File: rtl/mic_capture_ctrl_if.sv
// mic_capture_ctrl_if: Avalon-MM register bus between the host and the
// capture controller (fixed read latency 1, no waitrequest).
//   AS_ADDR      word address
//   AS_READ      read request
//   AS_WRITE     write request
//   AS_WRITEDATA write data
//   AS_READDATA  read data, valid the cycle after AS_READ
// master: bus host side; slave: controller side.
interface mic_capture_ctrl_if;
    logic [2:0]  AS_ADDR;
    logic        AS_READ;
    logic        AS_WRITE;
    logic [31:0] AS_WRITEDATA;
    logic [31:0] AS_READDATA;

    modport master (output AS_ADDR, AS_READ, AS_WRITE, AS_WRITEDATA,
                    input  AS_READDATA);
    modport slave  (input  AS_ADDR, AS_READ, AS_WRITE, AS_WRITEDATA,
                    output AS_READDATA);
endinterface

// File: rtl/mic_capture_ctrl_pacer.sv
// mic_sample_pacer: programmable-rate sample strobe generator.
//   CLK, RESET_N  clock, asynchronous active-low reset
//   enable        counter runs while high, held at 0 while low
//   div           period in cycles (caller guarantees div >= 2 while enabled)
//   strobe        high for one cycle when the counter reaches div-1
module mic_sample_pacer #(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_reg;
    logic             at_end;

    assign at_end = (cnt_reg == (div - ONE));
    assign strobe = enable & at_end;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_reg <= '0;
        end else if (!enable || at_end) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + ONE;
        end
    end
endmodule

// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: Avalon-MM slave that configures, paces and supervises
// the mic_dma engine for one capture session.
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   avs                          register bus (slave modport)
//   IRQ                          level interrupt, |(pending & enable)
//   start                        DMA session start level (ARM and RUN)
//   read_ready                   one-cycle sample strobe from the pacer
//   start_address/number_samples session configuration to the DMA
//   half_way_ack/end_ack         one-cycle acks of the DMA latches
//   DMA_RESET                    DMA reset during an abort
//   half_way_latch/end_latch     DMA level events
//   FINISHED                     DMA session complete
module mic_capture_ctrl
    import mic_ctrl_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    mic_capture_ctrl_if.slave    avs,
    output logic                 IRQ,
    output logic                 start,
    output logic                 read_ready,
    output logic [31:0]          start_address,
    output logic [31:0]          number_samples,
    output logic                 half_way_ack,
    output logic                 end_ack,
    output logic                 DMA_RESET,
    input  logic                 half_way_latch,
    input  logic                 end_latch,
    input  logic                 FINISHED
);
    ctrl_state_t      state_reg, state_next;
    logic [2:0]       phase_reg, phase_next;
    logic             half_ie_reg, end_ie_reg, done_ie_reg;
    logic             half_pend_reg, end_pend_reg, done_pend_reg;
    logic             aborted_reg, cfg_err_reg;
    logic [DIV_W-1:0] sample_div_reg;
    logic [31:0]      sample_count_reg;
    logic [31:0]      readdata_reg, rd_mux;
    logic             half_prev_reg, end_prev_reg;

    logic        wr_ctrl, go_req, abort_req, cfg_ok, busy;
    logic        go_accept, go_reject, set_done, set_aborted;
    logic        half_edge, end_edge;
    logic [31:0] w1c;

    assign wr_ctrl   = avs.AS_WRITE && (avs.AS_ADDR == ADDR_CTRL);
    // ABORT takes priority when both bits are written together.
    assign go_req    = wr_ctrl && avs.AS_WRITEDATA[CTRL_GO] && !avs.AS_WRITEDATA[CTRL_ABORT];
    assign abort_req = wr_ctrl && avs.AS_WRITEDATA[CTRL_ABORT];
    assign cfg_ok    = (number_samples != 32'd0) && (sample_div_reg >= DIV_W'(2));
    assign busy      = (state_reg != IDLE);
    assign w1c       = (avs.AS_WRITE && (avs.AS_ADDR == ADDR_STATUS)) ? avs.AS_WRITEDATA : 32'd0;

    // Edges only count during a session; the previous-value register tracks
    // the latch at all times, so a latch already high at ARM entry is no edge.
    assign half_edge = busy && half_way_latch && !half_prev_reg;
    assign end_edge  = busy && end_latch && !end_prev_reg;

    assign start     = (state_reg == ARM) || (state_reg == RUN);
    assign DMA_RESET = (state_reg == ABORTING);
    assign IRQ       = (half_pend_reg & half_ie_reg) | (end_pend_reg & end_ie_reg)
                     | (done_pend_reg & done_ie_reg);
    assign avs.AS_READDATA = readdata_reg;

    mic_sample_pacer #(.DIV_W(DIV_W)) u_pacer (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .enable  (state_reg == RUN),
        .div     (sample_div_reg),
        .strobe  (read_ready)
    );

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        go_accept   = 1'b0;
        go_reject   = 1'b0;
        set_done    = 1'b0;
        set_aborted = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go_req) begin
                    if (cfg_ok) begin
                        state_next = ARM;
                        phase_next = 3'd0;
                        go_accept  = 1'b1;
                    end else begin
                        go_reject = 1'b1;
                    end
                end
            end
            ARM: begin
                if (abort_req) begin
                    state_next = ABORTING;
                    phase_next = 3'd0;
                end else if (phase_reg == 3'(ARM_CYCLES - 1)) begin
                    state_next = RUN;
                end else begin
                    phase_next = phase_reg + 3'd1;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_next = ABORTING;
                    phase_next = 3'd0;
                end else if (FINISHED) begin
                    state_next = DONE;
                    set_done   = 1'b1;
                end
            end
            DONE: begin
                if (!FINISHED) state_next = IDLE;
            end
            ABORTING: begin
                if (phase_reg == 3'(ABORT_CYCLES - 1)) begin
                    state_next  = IDLE;
                    set_aborted = 1'b1;
                end else begin
                    phase_next = phase_reg + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (avs.AS_ADDR)
            ADDR_CTRL:        rd_mux[4:2] = {done_ie_reg, end_ie_reg, half_ie_reg};
            ADDR_STATUS:      rd_mux[8:0] = {state_reg, cfg_err_reg, aborted_reg, done_pend_reg,
                                             end_pend_reg, half_pend_reg, busy};
            ADDR_START_ADDR:  rd_mux = start_address;
            ADDR_NUM_SAMPLES: rd_mux = number_samples;
            ADDR_SAMPLE_DIV:  rd_mux[DIV_W-1:0] = sample_div_reg;
            ADDR_SAMPLE_CNT:  rd_mux = sample_count_reg;
            default:          rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg        <= IDLE;
            phase_reg        <= 3'd0;
            half_ie_reg      <= 1'b0;
            end_ie_reg       <= 1'b0;
            done_ie_reg      <= 1'b0;
            half_pend_reg    <= 1'b0;
            end_pend_reg     <= 1'b0;
            done_pend_reg    <= 1'b0;
            aborted_reg      <= 1'b0;
            cfg_err_reg      <= 1'b0;
            start_address    <= 32'd0;
            number_samples   <= 32'd0;
            sample_div_reg   <= '0;
            sample_count_reg <= 32'd0;
            readdata_reg     <= 32'd0;
            half_prev_reg    <= 1'b0;
            end_prev_reg     <= 1'b0;
            half_way_ack     <= 1'b0;
            end_ack          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            half_prev_reg <= half_way_latch;
            end_prev_reg  <= end_latch;
            half_way_ack  <= half_edge;
            end_ack       <= end_edge;

            if (wr_ctrl) begin
                half_ie_reg <= avs.AS_WRITEDATA[CTRL_HALF_IE];
                end_ie_reg  <= avs.AS_WRITEDATA[CTRL_END_IE];
                done_ie_reg <= avs.AS_WRITEDATA[CTRL_DONE_IE];
            end

            // Configuration is frozen for the whole session.
            if (avs.AS_WRITE && !busy) begin
                if (avs.AS_ADDR == ADDR_START_ADDR)  start_address  <= avs.AS_WRITEDATA;
                if (avs.AS_ADDR == ADDR_NUM_SAMPLES) number_samples <= avs.AS_WRITEDATA;
                if (avs.AS_ADDR == ADDR_SAMPLE_DIV)  sample_div_reg <= avs.AS_WRITEDATA[DIV_W-1:0];
            end

            // Clear first, then OR in the set so a same-cycle event survives.
            half_pend_reg <= (half_pend_reg & ~w1c[STAT_HALF_PEND]) | half_edge;
            end_pend_reg  <= (end_pend_reg  & ~w1c[STAT_END_PEND])  | end_edge;
            done_pend_reg <= (done_pend_reg & ~w1c[STAT_DONE_PEND]) | set_done;
            aborted_reg   <= (aborted_reg   & ~w1c[STAT_ABORTED])   | set_aborted;
            cfg_err_reg   <= (cfg_err_reg   & ~w1c[STAT_CFG_ERR])   | go_reject;

            if (go_accept) begin
                sample_count_reg <= 32'd0;
            end else if (read_ready && (sample_count_reg != 32'hFFFF_FFFF)) begin
                sample_count_reg <= sample_count_reg + 32'd1;
            end

            readdata_reg <= avs.AS_READ ? rd_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_mic_capture_ctrl.sv
module tb_mic_capture_ctrl;
    import mic_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IRQ, start, read_ready, half_way_ack, end_ack, DMA_RESET;
    logic [31:0] start_address, number_samples;
    logic        half_way_latch, end_latch, FINISHED;

    mic_capture_ctrl_if avs();

    mic_capture_ctrl #(.DIV_W(16)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .avs            (avs),
        .IRQ            (IRQ),
        .start          (start),
        .read_ready     (read_ready),
        .start_address  (start_address),
        .number_samples (number_samples),
        .half_way_ack   (half_way_ack),
        .end_ack        (end_ack),
        .DMA_RESET      (DMA_RESET),
        .half_way_latch (half_way_latch),
        .end_latch      (end_latch),
        .FINISHED       (FINISHED)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd_q[$];
    int          strobe_q[$];
    logic        exp_rr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs.AS_ADDR      = a;
        avs.AS_WRITEDATA = d;
        avs.AS_WRITE     = 1'b1;
        @(negedge CLK);
        avs.AS_WRITE     = 1'b0;
        $display("WR  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        avs.AS_ADDR = a;
        avs.AS_READ = 1'b1;
        @(negedge CLK);
        avs.AS_READ = 1'b0;
        $display("RD  %s addr=%0d data=0x%08h", tag, a, avs.AS_READDATA);
        check(tag, avs.AS_READDATA, rd_q.pop_front());
    endtask

    initial begin
        RESET_N = 1'b1;
        avs.AS_ADDR = 3'd0; avs.AS_READ = 1'b0; avs.AS_WRITE = 1'b0; avs.AS_WRITEDATA = 32'd0;
        half_way_latch = 1'b0; end_latch = 1'b0; FINISHED = 1'b0;
        #2 RESET_N = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_start", 32'(start), 32'd0);
        check("rst_read_ready", 32'(read_ready), 32'd0);
        check("rst_dma_reset", 32'(DMA_RESET), 32'd0);
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_start_address", start_address, 32'd0);
        check("rst_readdata", avs.AS_READDATA, 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        rd("rst_status", ADDR_STATUS, 32'd0);
        rd("rst_div", ADDR_SAMPLE_DIV, 32'd0);

        // Session 1: full run with latch events and DONE
        wr(ADDR_START_ADDR, 32'h0000_1000);
        wr(ADDR_NUM_SAMPLES, 32'd8);
        wr(ADDR_SAMPLE_DIV, 32'd10);
        for (int k = 0; k < 8; k++) strobe_q.push_back(13 + 10 * k);
        wr(ADDR_CTRL, 32'h0000_0005);            // GO + HALF_IE
        for (int cyc = 1; cyc <= 90; cyc++) begin
            exp_rr = (strobe_q.size() > 0) && (strobe_q[0] == cyc);
            if (exp_rr) void'(strobe_q.pop_front());
            check("s1_read_ready", 32'(read_ready), 32'(exp_rr));
            check("s1_start", 32'(start), 32'd1);
            check("s1_half_ack", 32'(half_way_ack), 32'(cyc == 31));
            check("s1_end_ack", 32'(end_ack), 32'(cyc == 51));
            check("s1_irq", 32'(IRQ), 32'((cyc >= 31) && (cyc <= 40)));
            check("s1_start_address", start_address, 32'h0000_1000);
            case (cyc)
                30: half_way_latch = 1'b1;
                40: begin avs.AS_ADDR = ADDR_STATUS; avs.AS_WRITEDATA = 32'h2; avs.AS_WRITE = 1'b1; end
                41: avs.AS_WRITE = 1'b0;
                50: end_latch = 1'b1;
                60: begin avs.AS_ADDR = ADDR_START_ADDR; avs.AS_WRITEDATA = 32'hDEAD; avs.AS_WRITE = 1'b1; end
                61: avs.AS_WRITE = 1'b0;
                90: begin FINISHED = 1'b1; half_way_latch = 1'b0; end_latch = 1'b0; end
                default: ;
            endcase
            @(negedge CLK);
        end
        $display("S1  session run complete, strobes left=%0d", strobe_q.size());
        check("s1_strobes_left", 32'(strobe_q.size()), 32'd0);
        check("s1_done_start", 32'(start), 32'd0);
        check("s1_done_read_ready", 32'(read_ready), 32'd0);
        check("s1_done_irq_off", 32'(IRQ), 32'd0);
        rd("s1_status_done", ADDR_STATUS, 32'h0000_00CD);
        rd("s1_sample_count", ADDR_SAMPLE_CNT, 32'd8);
        rd("s1_start_addr_reg", ADDR_START_ADDR, 32'h0000_1000);
        FINISHED = 1'b0;
        @(negedge CLK);
        wr(ADDR_CTRL, 32'h0000_0010);            // DONE_IE
        check("s1_done_irq_on", 32'(IRQ), 32'd1);
        wr(ADDR_STATUS, 32'h0000_000C);
        check("s1_irq_cleared", 32'(IRQ), 32'd0);
        rd("s1_status_idle", ADDR_STATUS, 32'd0);

        // Invalid configurations
        wr(ADDR_SAMPLE_DIV, 32'd1);
        wr(ADDR_CTRL, 32'h1);
        check("cfg_div_start", 32'(start), 32'd0);
        rd("cfg_div_status", ADDR_STATUS, 32'h20);
        wr(ADDR_STATUS, 32'h20);
        wr(ADDR_SAMPLE_DIV, 32'd10);
        wr(ADDR_NUM_SAMPLES, 32'd0);
        wr(ADDR_CTRL, 32'h1);
        check("cfg_num_start", 32'(start), 32'd0);
        rd("cfg_num_status", ADDR_STATUS, 32'h20);
        wr(ADDR_STATUS, 32'h20);
        wr(ADDR_NUM_SAMPLES, 32'd8);

        // GO and ABORT together: no session
        wr(ADDR_CTRL, 32'h3);
        check("goabort_start", 32'(start), 32'd0);
        rd("goabort_status", ADDR_STATUS, 32'd0);

        // Abort during RUN
        wr(ADDR_CTRL, 32'h1);
        check("ab_start_up", 32'(start), 32'd1);
        repeat (10) @(negedge CLK);
        wr(ADDR_CTRL, 32'h2);
        for (int k = 1; k <= 6; k++) begin
            check("ab_dma_reset", 32'(DMA_RESET), 32'(k <= 4));
            check("ab_start", 32'(start), 32'd0);
            @(negedge CLK);
        end
        rd("ab_status", ADDR_STATUS, 32'h10);
        wr(ADDR_STATUS, 32'h10);

        // W1C of DONE_PEND in the cycle DONE is entered
        wr(ADDR_CTRL, 32'h1);
        repeat (10) @(negedge CLK);
        FINISHED = 1'b1;
        avs.AS_ADDR = ADDR_STATUS; avs.AS_WRITEDATA = 32'h8; avs.AS_WRITE = 1'b1;
        @(negedge CLK);
        avs.AS_WRITE = 1'b0;
        check("w1c_start", 32'(start), 32'd0);
        rd("w1c_status", ADDR_STATUS, 32'h0000_00C9);
        FINISHED = 1'b0;
        @(negedge CLK);
        wr(ADDR_STATUS, 32'h8);

        // Asynchronous reset mid-RUN, then a fresh session
        wr(ADDR_SAMPLE_DIV, 32'd4);
        wr(ADDR_CTRL, 32'h1);
        repeat (10) @(negedge CLK);
        check("ar_start_before", 32'(start), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("ar_start", 32'(start), 32'd0);
        check("ar_dma_reset", 32'(DMA_RESET), 32'd0);
        check("ar_read_ready", 32'(read_ready), 32'd0);
        check("ar_irq", 32'(IRQ), 32'd0);
        check("ar_start_address", start_address, 32'd0);
        check("ar_number_samples", number_samples, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        rd("ar_status", ADDR_STATUS, 32'd0);
        wr(ADDR_START_ADDR, 32'h0000_2000);
        wr(ADDR_NUM_SAMPLES, 32'd3);
        wr(ADDR_SAMPLE_DIV, 32'd4);
        strobe_q.push_back(7); strobe_q.push_back(11); strobe_q.push_back(15);
        wr(ADDR_CTRL, 32'h1);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            exp_rr = (strobe_q.size() > 0) && (strobe_q[0] == cyc);
            if (exp_rr) void'(strobe_q.pop_front());
            check("s4_read_ready", 32'(read_ready), 32'(exp_rr));
            check("s4_start", 32'(start), 32'd1);
            if (cyc == 15) FINISHED = 1'b1;
            @(negedge CLK);
        end
        check("s4_start_address", start_address, 32'h0000_2000);
        rd("s4_sample_count", ADDR_SAMPLE_CNT, 32'd3);
        FINISHED = 1'b0;
        @(negedge CLK);
        rd("s4_status", ADDR_STATUS, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
